// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI-style SRAM responder with grant wait states and fixed response latency
module obi_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int GNT_WAIT  = 0,
    parameter int RESP_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;
    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [31:0]     mem [MEM_WORDS];
    logic [33:0]     pipe [RESP_LAT];
    logic [AW-1:0]   word;
    logic            in_range, acc;
    assign word     = addr_i[AW+1:2];
    assign in_range = (addr_i >> 2) < 32'(MEM_WORDS);
    assign acc      = req_i && gnt_o;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    // A dropped request anywhere in the handshake abandons it and restarts the wait
    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        if (GNT_WAIT != 0 && req_i && state == IDLE) begin
            cnt_n   = 4'd1;
            state_n = (GNT_WAIT == 1) ? GRANT : WAIT;
        end else if (GNT_WAIT != 0 && req_i && state == WAIT) begin
            cnt_n   = cnt + 4'd1;
            state_n = (cnt_n == 4'(GNT_WAIT)) ? GRANT : WAIT;
        end
    end
    always_comb gnt_o = rst_ni && req_i && (GNT_WAIT == 0 || state == GRANT);
    always_ff @(posedge clk_i)
        if (acc && we_i && in_range)
            for (int k = 0; k < 4; k++)
                if (be_i[k]) mem[word][8*k +: 8] <= wdata_i[8*k +: 8];
    // Each stage holds {valid, err, data}; data is only non-zero for in-range reads
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            for (int i = 0; i < RESP_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {acc, acc && !in_range, (acc && !we_i && in_range) ? mem[word] : 32'h0};
            for (int i = 1; i < RESP_LAT; i++) pipe[i] <= pipe[i-1];
        end
    assign {rvalid_o, err_o, rdata_o} = pipe[RESP_LAT-1];
endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder: scoreboarded random bench over three latency/wait configurations
module tb_obi_mem_responder;
    logic        clk = 0;
    logic        rst_n [3];
    logic        req [3], we [3], gnt [3], rvalid [3], err [3];
    logic [31:0] addr [3], wdata [3], rdata [3];
    logic [3:0]  be [3];
    int          gw [3]  = '{0, 3, 0};
    int          lat [3] = '{1, 2, 3};
    int          cyc = 0, tests = 0, fails = 0;
    typedef struct {logic err; logic [31:0] data; int due;} exp_t;
    exp_t        q [3][$];
    logic [31:0] mdl [3][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RESP_LAT(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));
    obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(3), .RESP_LAT(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));
    obi_mem_responder #(.MEM_WORDS(1024), .GNT_WAIT(0), .RESP_LAT(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
        .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2]));

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(int d, int i, logic [31:0] v);
        mdl[d][i] = v;
        case (d)
            0: u0.mem[i] = v;
            1: u1.mem[i] = v;
            default: u2.mem[i] = v;
        endcase
    endtask

    function automatic logic [31:0] peek(int d, int i);
        case (d)
            0: return u0.mem[i];
            1: return u1.mem[i];
            default: return u2.mem[i];
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept
    task automatic txn(int d, logic w, logic [31:0] a, logic [3:0] b, logic [31:0] wd);
        int   n = 0;
        int   idx;
        exp_t e;
        req[d] = 1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        #2;
        while (gnt[d] !== 1'b1 && n < 64) begin
            @(posedge clk); #3;
            n++;
        end
        chk($sformatf("dut%0d_gnt_wait", d), 64'(n), 64'(gw[d]));
        if (n >= 64) begin
            req[d] = 0;
            @(posedge clk); #1;
            return;
        end
        idx   = int'(a[31:2]);
        e.due = cyc + lat[d];
        e.err = idx >= 1024;
        e.data = 0;
        if (idx < 1024 && w) begin
            for (int k = 0; k < 4; k++) if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
        end else if (idx < 1024) e.data = mdl[d][idx];
        q[d].push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(int d, int n);
        req[d] = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_txns(int d, int count, int gapmax, int span);
        logic [31:0] a;
        for (int t = 0; t < count; t++) begin
            if ($urandom_range(7) == 0) a = {$urandom_range(16383, 1024), 2'($urandom)};
            else a = {$urandom_range(span - 1, 0), 2'($urandom)};
            txn(d, 1'($urandom), a, 4'($urandom), $urandom);
            if (gapmax > 0) idle(d, $urandom_range(gapmax, 0));
        end
        idle(d, 1);
    endtask

    always @(negedge clk)
        for (int d = 0; d < 3; d++)
            if (rvalid[d] === 1'b1) begin
                if (q[d].size() == 0) begin
                    tests++; fails++;
                    $display("FAIL dut%0d_unexpected_rvalid: got rdata %0h err %0b expected no response", d, rdata[d], err[d]);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    chk($sformatf("dut%0d_resp_cycle", d), 64'(cyc), 64'(e.due));
                    chk($sformatf("dut%0d_resp_err", d), 64'(err[d]), 64'(e.err));
                    chk($sformatf("dut%0d_resp_data", d), 64'(rdata[d]), 64'(e.data));
                end
            end

    initial begin
        int mism;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 0; req[d] = 0; we[d] = 0; addr[d] = 0; be[d] = 0; wdata[d] = 0;
            for (int i = 0; i < 1024; i++) preload(d, i, $urandom);
        end
        repeat (2) @(posedge clk);
        #3;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_rst_gnt", d), 64'(gnt[d]), 0);
            chk($sformatf("dut%0d_rst_rvalid", d), 64'(rvalid[d]), 0);
            chk($sformatf("dut%0d_rst_rdata", d), 64'(rdata[d]), 0);
            chk($sformatf("dut%0d_rst_err", d), 64'(err[d]), 0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst_n[d] = 1;
        @(posedge clk); #1;
        // zero-wait, single-cycle latency: write-then-read, byte merge, out of range
        txn(0, 1, 32'h4, 4'hF, 32'hDEADBEEF);
        txn(0, 0, 32'h4, 4'h0, 32'h0);
        preload(0, 2, 32'h11223344);
        txn(0, 1, 32'h8, 4'b0101, 32'hAABBCCDD);
        txn(0, 0, 32'h8, 4'h0, 32'h0);
        txn(0, 0, 32'h1000, 4'h0, 32'h0);
        txn(0, 1, 32'h2000, 4'hF, 32'hFFFFFFFF);
        idle(0, 2);
        chk("dut0_word1", 64'(peek(0, 1)), 64'h00000000DEADBEEF);
        chk("dut0_be_merge", 64'(peek(0, 2)), 64'h0000000011BB33DD);
        rand_txns(0, 30, 0, 16);
        rand_txns(0, 30, 2, 1024);
        // wait states: preloaded read, then an abandoned request
        preload(1, 0, 32'h5);
        txn(1, 0, 32'h0, 4'h0, 32'h0);
        idle(1, 1);
        req[1] = 1; addr[1] = 32'h4; we[1] = 0;
        #2;
        chk("dut1_no_gnt_on_rise", 64'(gnt[1]), 0);
        @(posedge clk); #1;
        idle(1, 1);
        rand_txns(1, 15, 2, 16);
        // deep latency: streaming reads, then a reset that must swallow a response
        for (int i = 0; i < 4; i++) txn(2, 0, 32'(i * 4), 4'h0, 32'h0);
        idle(2, 5);
        txn(2, 0, 32'h10, 4'h0, 32'h0);
        req[2] = 0;
        rst_n[2] = 0;
        q[2].delete();
        #2;
        chk("dut2_midrst_gnt", 64'(gnt[2]), 0);
        @(posedge clk); #1;
        rst_n[2] = 1;
        repeat (5) begin
            #2;
            chk("dut2_midrst_no_rvalid", 64'(rvalid[2]), 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) txn(2, 0, 32'(i * 4 + 16), 4'h0, 32'h0);
        rand_txns(2, 30, 1, 32);
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_pending_responses", d), 64'(q[d].size()), 0);
            mism = 0;
            for (int i = 0; i < 1024; i++) if (peek(d, i) !== mdl[d][i]) mism++;
            chk($sformatf("dut%0d_mem_mismatches", d), 64'(mism), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
